// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Executes MULTU/MULT/DIVU/DIV one bit per cycle (shift-add multiply,
// restoring divide) and services MTHI/MTLO writes. The controller talks to
// it through a start/busy/done handshake and uses stall to hold the
// pipeline while an operation is in flight.
//
// Ports:
//   clk, reset        clock (rising edge) and asynchronous active-high reset
//   start, op         issue an operation (00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   a, b              rs / rt operands, sampled only on the accepting edge
//   hi_we, lo_we      MTHI / MTLO write enables, data on wdata
//   rd_req            MFHI / MFLO read in progress
//   hi, lo            HI / LO registers
//   busy              operation in flight
//   done              one-cycle pulse when an operation has written HI/LO
//   dbz               divide-by-zero flag of the most recent operation
//   stall             busy while the controller touches HI/LO or issues an op
//
// Build option: define MULDIV_EARLY_OUT_EN to let a multiply finish as soon
// as its remaining multiplier bits are all zero. Without it every operation
// except divide-by-zero takes WIDTH+1 cycles.

module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             stall
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t state, nextState;

    logic [1:0]         opReg;
    logic               isDbz;
    logic               negResult;
    logic               negRem;
    logic [2*WIDTH-1:0] accReg;
    logic [2*WIDTH-1:0] mcandReg;
    logic [WIDTH-1:0]   bReg;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic               doneReg;
    logic               dbzReg;

    logic               accept;
    logic               divZero;
    logic               aNeg, bNeg;
    logic [WIDTH-1:0]   aMag, bMag;
    logic [2*WIDTH-1:0] mulSum;
    logic [WIDTH-1:0]   mplierRest;
    logic [WIDTH:0]     divShifted;
    logic [WIDTH:0]     divTrial;
    logic               divFits;
    logic [WIDTH-1:0]   divRem;
    logic [2*WIDTH-1:0] divNext;
    logic               lastStep;
    logic               earlyOut;
    logic               fixDone;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quoFix, remFix;
    logic [WIDTH-1:0]   resHi, resLo;

    // Operand conditioning: signed ops work on magnitudes and fix the sign at the end.
    assign accept  = (state == IDLE) && start;
    assign divZero = op[1] && (b == '0);
    assign aNeg    = op[0] && a[WIDTH-1];
    assign bNeg    = op[0] && b[WIDTH-1];
    assign aMag    = aNeg ? (~a + WIDTH'(1)) : a;
    assign bMag    = bNeg ? (~b + WIDTH'(1)) : b;

    // One multiply step: add the shifted multiplicand when the current multiplier bit is set.
    assign mulSum     = accReg + (bReg[0] ? mcandReg : '0);
    assign mplierRest = bReg >> 1;

    // One restoring divide step on {remainder, dividend/quotient} held in accReg.
    assign divShifted = {accReg[2*WIDTH-1:WIDTH], accReg[WIDTH-1]};
    assign divTrial   = divShifted - {1'b0, bReg};
    assign divFits    = ~divTrial[WIDTH];
    assign divRem     = divFits ? divTrial[WIDTH-1:0] : divShifted[WIDTH-1:0];
    assign divNext    = {divRem, accReg[WIDTH-2:0], divFits};

    assign lastStep = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_EARLY_OUT_EN
    assign earlyOut = ~opReg[1] && (mplierRest == '0);
`else
    assign earlyOut = 1'b0;
`endif

    // Sign correction applied in FIX. Quotient overflow (most negative / -1)
    // wraps back to the most negative value through the modular negation.
    assign prodFix = negResult ? (~accReg + (2*WIDTH)'(1)) : accReg;
    assign quoFix  = negResult ? (~accReg[WIDTH-1:0] + WIDTH'(1)) : accReg[WIDTH-1:0];
    assign remFix  = negRem ? (~accReg[2*WIDTH-1:WIDTH] + WIDTH'(1)) : accReg[2*WIDTH-1:WIDTH];

    // Result selection; a divide-by-zero already parked {a, all ones} in accReg.
    always_comb begin
        resHi = prodFix[2*WIDTH-1:WIDTH];
        resLo = prodFix[WIDTH-1:0];
        if (isDbz) begin
            resHi = accReg[2*WIDTH-1:WIDTH];
            resLo = accReg[WIDTH-1:0];
        end else if (opReg[1]) begin
            resHi = remFix;
            resLo = quoFix;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. Divide-by-zero spends two cycles in FIX so that it
    // completes two edges after acceptance, like the shortest early-out multiply.
    always_comb begin
        nextState = state;
        fixDone   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = divZero ? FIX : RUN;
                end
            end
            RUN: begin
                if (lastStep || earlyOut) begin
                    nextState = FIX;
                end
            end
            FIX: begin
                if (!(isDbz && cnt == '0)) begin
                    nextState = IDLE;
                    fixDone   = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Iteration datapath: latch operands on accept, then one step per RUN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opReg     <= '0;
            isDbz     <= 1'b0;
            negResult <= 1'b0;
            negRem    <= 1'b0;
            accReg    <= '0;
            mcandReg  <= '0;
            bReg      <= '0;
            cnt       <= '0;
        end else begin
            if (accept) begin
                opReg <= op;
                isDbz <= divZero;
                cnt   <= '0;
                if (divZero) begin
                    accReg    <= {a, {WIDTH{1'b1}}};
                    negResult <= 1'b0;
                    negRem    <= 1'b0;
                end else if (op[1]) begin
                    accReg    <= {{WIDTH{1'b0}}, aMag};
                    bReg      <= bMag;
                    negResult <= aNeg ^ bNeg;
                    negRem    <= aNeg;
                end else begin
                    accReg    <= '0;
                    mcandReg  <= {{WIDTH{1'b0}}, aMag};
                    bReg      <= bMag;
                    negResult <= aNeg ^ bNeg;
                    negRem    <= 1'b0;
                end
            end else if (state == RUN) begin
                cnt <= cnt + CNT_W'(1);
                if (opReg[1]) begin
                    accReg <= divNext;
                end else begin
                    accReg   <= mulSum;
                    mcandReg <= mcandReg << 1;
                    bReg     <= mplierRest;
                end
            end else if (state == FIX && !fixDone) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Architectural HI/LO plus completion flags. MTHI/MTLO only land while idle;
    // an op accepted in the same cycle overwrites them later in FIX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hiReg   <= '0;
            loReg   <= '0;
            doneReg <= 1'b0;
            dbzReg  <= 1'b0;
        end else begin
            doneReg <= fixDone;
            if (fixDone) begin
                hiReg  <= resHi;
                loReg  <= resLo;
                dbzReg <= isDbz;
            end else if (state == IDLE) begin
                if (hi_we) begin
                    hiReg <= wdata;
                end
                if (lo_we) begin
                    loReg <= wdata;
                end
            end
        end
    end

    assign hi    = hiReg;
    assign lo    = loReg;
    assign done  = doneReg;
    assign dbz   = dbzReg;
    assign busy  = (state != IDLE);
    assign stall = busy && (start || hi_we || lo_we || rd_req);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//
// Directed testbench for muldiv_sequencer with hand-computed expected values
// (default build, early-out disabled). Inputs are driven on the falling edge,
// outputs are sampled 1ns after the rising edge.

module tb_muldiv_sequencer;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             rd_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             dbz;
    logic             stall;

    int testsRun  = 0;
    int testsFail = 0;
    int edgeCnt   = 0;
    int startEdge = 0;

    muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .rd_req (rd_req),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done),
        .dbz    (dbz),
        .stall  (stall)
    );

    // 10ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge counter used to measure latency from the accepting edge.
    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one operation: start high across exactly one rising edge (edge 0),
    // then scramble the operands to show they are not re-sampled.
    task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn);
        @(negedge clk);
        start = 1'b1;
        op    = opIn;
        a     = aIn;
        b     = bIn;
        @(posedge clk);
        #1;
        startEdge = edgeCnt;
        start = 1'b0;
        a     = 32'h5A5A_5A5A;
        b     = 32'h0000_0003;
    endtask

    // Wait (bounded) for done, then check latency, results, and that busy stayed high.
    task automatic waitDone(input string tag, input int expLat, input logic [31:0] expHi,
                            input logic [31:0] expLo, input logic expDbz, input bit checkPulse);
        int  guard;
        bit  busyDropped;
        guard       = 0;
        busyDropped = 1'b0;
        while (!done && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
            if (!done && !busy) busyDropped = 1'b1;
        end
        if (!done) begin
            checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            checkOutput({tag, "_latency"}, 64'(edgeCnt - startEdge), 64'(expLat));
            checkOutput({tag, "_hi"}, 64'(hi), 64'(expHi));
            checkOutput({tag, "_lo"}, 64'(lo), 64'(expLo));
            checkOutput({tag, "_dbz"}, 64'(dbz), 64'(expDbz));
            checkOutput({tag, "_busyHeld"}, 64'(busyDropped), 64'd0);
            checkOutput({tag, "_busyLow"}, 64'(busy), 64'd0);
            if (checkPulse) begin
                @(posedge clk);
                #1;
                checkOutput({tag, "_donePulse"}, 64'(done), 64'd0);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = '0;
        rd_req = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_hi", 64'(hi), 64'd0);
        checkOutput("rst_lo", 64'(lo), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_dbz", 64'(dbz), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // MTHI / MTLO while idle, and MFHI/MFLO read in idle does not stall.
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        #1;
        checkOutput("idle_mthi_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        checkOutput("idle_mthi", 64'(hi), 64'h1234);
        @(negedge clk);
        lo_we = 1'b1;
        wdata = 32'h0000_ABCD;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        checkOutput("idle_mtlo", 64'(lo), 64'hABCD);
        checkOutput("idle_mtlo_hiKept", 64'(hi), 64'h1234);
        rd_req = 1'b1;
        #1;
        checkOutput("idle_rd_stall", 64'(stall), 64'd0);
        rd_req = 1'b0;

        // MULTU 0xFFFFFFFF * 0xFFFFFFFF.
        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("multu_busyRise", 64'(busy), 64'd1);
        waitDone("multu", 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);

        // MULT -3 * 5 = -15.
        applyStimulus(2'b01, 32'hFFFF_FFFD, 32'h0000_0005);
        waitDone("mult", 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1);

        // Start, MTHI and MFHI while busy are stalled and ignored.
        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        a     = 32'h0000_0005;
        b     = 32'h0000_0007;
        #1;
        checkOutput("busy_start_stall", 64'(stall), 64'd1);
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        #1;
        checkOutput("busy_mthi_stall", 64'(stall), 64'd1);
        @(negedge clk);
        hi_we  = 1'b0;
        rd_req = 1'b1;
        #1;
        checkOutput("busy_rd_stall", 64'(stall), 64'd1);
        checkOutput("busy_mthi_ignored", 64'(hi), 64'hFFFF_FFFF);
        rd_req = 1'b0;
        waitDone("busyops", 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);

        // DIV -7 / 2 = -3 remainder -1.
        applyStimulus(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
        waitDone("div", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);

        // DIVU by zero, then MTHI leaves dbz alone.
        applyStimulus(2'b10, 32'h0000_0064, 32'h0000_0000);
        waitDone("dbz", 2, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1'b1);
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h0000_0077;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        checkOutput("dbz_keptByMthi", 64'(dbz), 64'd1);
        checkOutput("dbz_mthi", 64'(hi), 64'h77);

        // DIVU 100 / 7 = 14 r 2; next op issued in the cycle done is high.
        applyStimulus(2'b10, 32'h0000_0064, 32'h0000_0007);
        waitDone("divu", 33, 32'h0000_0002, 32'h0000_000E, 1'b0, 1'b0);
        applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone("divOvf", 33, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);

        // Reset in the middle of a DIV aborts it and clears HI/LO at once.
        applyStimulus(2'b11, 32'h0000_0064, 32'h0000_0007);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        checkOutput("midrst_hi", 64'(hi), 64'd0);
        checkOutput("midrst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // MULTU 3 * 4 after reset.
        applyStimulus(2'b00, 32'h0000_0003, 32'h0000_0004);
        waitDone("multuPostRst", 33, 32'h0000_0000, 32'h0000_000C, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multiply/divide unit with architectural HI/LO registers. It executes MIPS MULT/MULTU/DIV/DIVU and services MTHI/MTLO/MFHI/MFLO. It sits beside the ALU in the datapath and is sequenced by the controller through a start/busy/done handshake. It raises `stall` to freeze the PC and register writeback whenever the controller touches HI/LO or issues a new op while an operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width.
CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  issue operation this cycle
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  input  WIDTH  rs operand: multiplicand or dividend
b  input  WIDTH  rt operand: multiplier or divisor
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO data
rd_req  input  1  MFHI/MFLO read this cycle
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  operation in flight
done  output  1  one-cycle pulse when HI/LO have been updated by an op
dbz  output  1  sticky divide-by-zero flag of the last op
stall  output  1  busy & (start | hi_we | lo_we | rd_req); combinational

Behaviour:
- Reset, asynchronous: state=IDLE; hi=0, lo=0, busy=0, done=0, dbz=0, counter=0. Reset mid-operation aborts the op, and HI/LO read 0.
- States: IDLE, RUN, FIX.
- IDLE with start=1: latch op; convert a and b to magnitudes for signed ops; record sign of result and sign of dividend; counter=0; busy=1 from the next cycle. Next state is RUN. The exception is a DIV/DIVU with b==0, which goes directly to FIX.
- RUN, multiply: one shift-add step per cycle on a 2*WIDTH accumulator.
- RUN, divide: one restoring step per cycle (shift remainder left, trial subtract, quotient bit).
- RUN exit: after WIDTH steps, at the edge where counter reaches WIDTH-1, go to FIX.
- FIX: apply sign correction and write HI/LO. Then go to IDLE, busy=0, done=1 for exactly one cycle.
  - MULT product is negated if operand signs differ; hi=product[63:32], lo=product[31:0].
  - DIV quotient is negated if signs differ; remainder takes the sign of the dividend; lo=quotient, hi=remainder.
  - Overflow case 0x80000000 / -1: lo=0x80000000, hi=0. This falls out of the modular negation; no special case is needed.
- Divide by zero: FIX writes hi=a (original value), lo=0xFFFFFFFF, and sets dbz=1. Otherwise dbz is set to 0 at every op completion. dbz is unchanged by MTHI/MTLO.
- Latency, start sampled at edge 0:
  - normal op: hi/lo update and done=1 at edge 33 (WIDTH+1);
  - divide by zero: at edge 2.
- start while busy: ignored (no re-latch); stall=1.
- hi_we/lo_we while busy: ignored; stall=1. The controller holds the instruction until busy falls.
- hi_we/lo_we in IDLE: the register takes wdata at the next edge.
- hi_we/lo_we together with start in IDLE: the write is applied, and the op result later overwrites it.
- rd_req while busy: stall=1; hi/lo outputs are stale, and the controller must not consume them.
- rd_req in IDLE: no effect; hi/lo are always driven directly from the registers.
- Operand inputs a/b are sampled only on the accepting edge; changes during RUN have no effect.
- done is cleared on the edge after it rises. The next op can be started in the same cycle done=1.

Optional Feature:
- MULDIV_EARLY_OUT_EN defined: in a multiply RUN, if the remaining (shifted) multiplier bits are all zero, go to FIX on that edge; the accumulator is shifted into final position so results are identical. Latency becomes variable, minimum 2 cycles (b==0). Divide latency is unchanged.
- Not defined: every multiply takes exactly WIDTH+1 cycles.

Test Plan:
- MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> at edge 33: hi=0xFFFFFFFE, lo=0x00000001, done pulse 1 cycle, busy 1 on edges 1-32, dbz=0.
- MULT, a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU, a=0x64, b=0 -> done at edge 2, hi=0x00000064, lo=0xFFFFFFFF, dbz=1; a following DIVU 0x64/0x7 -> lo=0xE, hi=0x2, dbz=0.
- During a MULTU busy window, assert start with new operands, then hi_we with wdata=0x1234 -> stall=1 each cycle, both ignored, original result written at edge 33.
- IDLE: hi_we=1, wdata=0x1234 -> hi=0x1234 next edge; lo_we=1, wdata=0xABCD -> lo=0xABCD; rd_req in IDLE -> stall=0.
- Start DIV, assert reset at cycle 10 -> busy=0, done=0, hi=lo=0 immediately; a new MULTU 3*4 after reset -> lo=0xC, hi=0 at edge 33.
